// File: rtl/spi_slave_core_if.sv
// spi_slave_core_if
//   Groups the SPI pins and the parallel-side control/data/status of the
//   SPI slave engine into one bundle.
//   slave  modport: view taken by spi_slave_core (pins in, miso out,
//                   control in, status out).
//   master modport: view taken by whatever drives the core (host pins,
//                   register side).
//   Signals:
//     spe, cpol, cpha, dord, spie   engine enable, mode bits, interrupt enable
//     sck, ss_n, mosi / miso, miso_oe   SPI pins and tristate enable
//     tx_data, tx_valid / tx_ready      TX holding register handshake
//     rx_data, rx_valid, rx_avail / rx_ack   received byte and status
//     rx_overrun, tx_underrun, frame_err / flag_clr   sticky error flags
//     busy, spi_int                     frame active, interrupt request
interface spi_slave_core_if;
    logic       spe;
    logic       cpol;
    logic       cpha;
    logic       dord;
    logic       spie;
    logic       sck;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_avail;
    logic       rx_ack;
    logic       rx_overrun;
    logic       tx_underrun;
    logic       frame_err;
    logic       flag_clr;
    logic       busy;
    logic       spi_int;

    modport slave (
        input  spe, cpol, cpha, dord, spie,
        input  sck, ss_n, mosi,
        output miso, miso_oe,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid, rx_avail,
        input  rx_ack,
        output rx_overrun, tx_underrun, frame_err,
        input  flag_clr,
        output busy, spi_int
    );

    modport master (
        output spe, cpol, cpha, dord, spie,
        output sck, ss_n, mosi,
        input  miso, miso_oe,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid, rx_avail,
        output rx_ack,
        input  rx_overrun, tx_underrun, frame_err,
        output flag_clr,
        input  busy, spi_int
    );
endinterface

// File: rtl/spi_slave_core.sv
// spi_slave_core
//   SPI slave engine. SCK/SS_n/MOSI are oversampled in the Bus2IP_Clk domain,
//   full-duplex 8-bit bytes are exchanged in SPI modes 0-3 with either bit
//   order. The parallel side has a one-byte TX holding register and an RX
//   data register with sticky status flags.
//   Ports:
//     Bus2IP_Clk     system clock, rising edge
//     Bus2IP_Resetn  asynchronous active-low reset
//     bus            spi_slave_core_if.slave (pins, control, data, status)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | synced ss_n high, miso tristated, SCK edges ignored
//   S_ACTIVE | frame in progress, miso driven, bytes shifted on SCK edges
module spi_slave_core #(
    parameter logic [7:0] C_FILL        = 8'hFF,
    parameter int         C_SYNC_STAGES = 2
) (
    input  logic            Bus2IP_Clk,
    input  logic            Bus2IP_Resetn,
    spi_slave_core_if.slave bus
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    logic [C_SYNC_STAGES-1:0] r_sck_sync;
    logic [C_SYNC_STAGES-1:0] r_ss_sync;
    logic [C_SYNC_STAGES-1:0] r_mosi_sync;
    logic                     r_sck_prev;

    state_t     r_state;
    logic [2:0] r_bcnt;
    logic [7:0] r_tx_sr;
    logic [7:0] r_rx_sr;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_rx_avail;
    logic       r_rx_overrun;
    logic       r_tx_underrun;
    logic       r_frame_err;
    logic       r_miso_oe;

    logic       w_sck;
    logic       w_ss;
    logic       w_mosi;
    logic       w_lead;
    logic       w_trail;
    logic       w_sample;
    logic       w_drive;
    logic       w_active;
    logic       w_start;
    logic       w_stop;
    logic       w_byte_done;
    logic       w_load;
    logic       w_abort;
    logic       w_underrun;
    logic       w_tx_write;
    logic [7:0] w_rx_next;
    logic [7:0] w_tx_shift;
    logic [7:0] w_load_byte;

    // SCK is synchronised already normalised against cpol, so a 0->1 change
    // is always the leading edge and the idle level resets cleanly to 0.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
        end else if (!bus.spe) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[C_SYNC_STAGES-2:0], bus.sck ^ bus.cpol};
            r_ss_sync   <= {r_ss_sync[C_SYNC_STAGES-2:0], bus.ss_n};
            r_mosi_sync <= {r_mosi_sync[C_SYNC_STAGES-2:0], bus.mosi};
            r_sck_prev  <= w_sck;
        end
    end

    assign w_sck    = r_sck_sync[C_SYNC_STAGES-1];
    assign w_ss     = r_ss_sync[C_SYNC_STAGES-1];
    assign w_mosi   = r_mosi_sync[C_SYNC_STAGES-1];
    assign w_lead   = w_sck & ~r_sck_prev;
    assign w_trail  = ~w_sck & r_sck_prev;
    assign w_sample = bus.cpha ? w_trail : w_lead;
    assign w_drive  = bus.cpha ? w_lead : w_trail;

    assign w_active    = (r_state == S_ACTIVE);
    assign w_start     = ~w_active & ~w_ss;
    assign w_stop      = w_active & w_ss;
    assign w_byte_done = w_active & ~w_ss & w_sample & (r_bcnt == 3'd7);
    assign w_load      = w_start | w_byte_done;
    assign w_abort     = w_stop & (r_bcnt != 3'd0);

    assign w_rx_next  = bus.dord ? {w_mosi, r_rx_sr[7:1]} : {r_rx_sr[6:0], w_mosi};
    assign w_tx_shift = bus.dord ? {1'b0, r_tx_sr[7:1]} : {r_tx_sr[6:0], 1'b0};

    // A byte offered on the load cycle with an empty holding register goes
    // straight into the shifter instead of the holding register.
    assign w_load_byte = r_hold_full ? r_hold : (bus.tx_valid ? bus.tx_data : C_FILL);
    assign w_underrun  = w_load & ~r_hold_full & ~bus.tx_valid;
    assign w_tx_write  = bus.tx_valid & ~r_hold_full & ~w_load;

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_state       <= S_IDLE;
            r_bcnt        <= 3'd0;
            r_tx_sr       <= 8'h00;
            r_rx_sr       <= 8'h00;
            r_hold        <= 8'h00;
            r_hold_full   <= 1'b0;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_rx_avail    <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
            r_miso_oe     <= 1'b0;
        end else if (!bus.spe) begin
            r_state       <= S_IDLE;
            r_bcnt        <= 3'd0;
            r_tx_sr       <= 8'h00;
            r_rx_sr       <= 8'h00;
            r_hold        <= 8'h00;
            r_hold_full   <= 1'b0;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_rx_avail    <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
            r_miso_oe     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!w_ss) begin
                        r_state   <= S_ACTIVE;
                        r_miso_oe <= 1'b1;
                        r_bcnt    <= 3'd0;
                    end
                end
                S_ACTIVE: begin
                    if (w_ss) begin
                        r_state   <= S_IDLE;
                        r_miso_oe <= 1'b0;
                        r_bcnt    <= 3'd0;
                        r_tx_sr   <= 8'h00;
                    end else if (w_sample) begin
                        r_rx_sr <= w_rx_next;
                        r_bcnt  <= r_bcnt + 3'd1;
                        if (r_bcnt == 3'd7) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                        end
                    end else if (w_drive && (r_bcnt != 3'd0)) begin
                        // bit 0 of each byte is already on miso from the load
                        r_tx_sr <= w_tx_shift;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_load) begin
                r_tx_sr     <= w_load_byte;
                r_hold_full <= 1'b0;
            end else if (w_tx_write) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end

            // set terms take priority over ack/clear
            r_rx_avail    <= w_byte_done | (r_rx_avail & ~bus.rx_ack);
            r_rx_overrun  <= (w_byte_done & r_rx_avail & ~bus.rx_ack) |
                             (r_rx_overrun & ~bus.flag_clr);
            r_tx_underrun <= w_underrun | (r_tx_underrun & ~bus.flag_clr);
            r_frame_err   <= w_abort | (r_frame_err & ~bus.flag_clr);
        end
    end

    assign bus.miso        = r_miso_oe & (bus.dord ? r_tx_sr[0] : r_tx_sr[7]);
    assign bus.miso_oe     = r_miso_oe;
    assign bus.tx_ready    = ~r_hold_full;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.rx_avail    = r_rx_avail;
    assign bus.rx_overrun  = r_rx_overrun;
    assign bus.tx_underrun = r_tx_underrun;
    assign bus.frame_err   = r_frame_err;
    assign bus.busy        = w_active;
    assign bus.spi_int     = bus.spie & (r_rx_avail | r_rx_overrun);

endmodule
